// File: rtl/uart_rx_to_mem.sv
// UART receiver that streams MAT_ELEMS bytes into consecutive operand-RAM addresses.
// Optional even-parity framing (8E1) when UART_PARITY_EN is defined; default build is 8N1.
module uart_rx_to_mem #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int MAT_ELEMS    = 18,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_done,
  output logic              frame_err
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TICK_W-1:0] FULL_M1   = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_M1   = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   LAST_ELEM = (ADDR_W + 1)'(MAT_ELEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ferr_q, ferr_d;
`ifdef UART_PARITY_EN
  logic                par_err_q, par_err_d;
`endif

  // rx is asynchronous; the sync chain resets to the idle level so no false edge follows reset
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_data;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    count_d   = count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ferr_d    = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (load_en && rx_fall) state_d = S_START;
      end
      S_START: begin
        if (tick_q == HALF_M1) begin
          tick_d  = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          shift_d = {rx_sync_q, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tick_q == FULL_M1) begin
          tick_d    = '0;
          par_err_d = (rx_sync_q != ^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d = '0;
`ifdef UART_PARITY_EN
          if (rx_sync_q && !par_err_q) begin
`else
          if (rx_sync_q) begin
`endif
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = shift_q;
          end else begin
            state_d = S_IDLE;
            ferr_d  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = (count_q == LAST_ELEM) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        tick_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping load_en aborts any partial frame and rearms the load from address 0
    if (!load_en) begin
      state_d = S_IDLE;
      count_d = '0;
      we_d    = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign frame_err = ferr_q;
  assign load_done = (state_q == S_DONE);

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Randomised bench for uart_rx_to_mem: bytes are sent as serial frames and the resulting
// RAM writes / frame errors are compared against a queue-based model of the load protocol.
module tb_uart_rx_to_mem;
  localparam int CPB = 16;
  localparam int DW  = 8;
  localparam int NE  = 18;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          load_done;
  logic          frame_err;

  uart_rx_to_mem #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW),
    .MAT_ELEMS   (NE),
    .ADDR_W      (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .load_done(load_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   stop_cyc = 0;
  int   obs_ferr = 0;
  int   exp_ferr = 0;
  int   exp_count = 0;
  bit   exp_done = 1'b0;
  int   nbytes = 0;
  wr_t  obs_q[$];
  wr_t  exp_q[$];
  logic prev_we = 1'b0;
  logic prev_fe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Monitor: collects writes and frame errors, and checks strobe width and write latency
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        obs_q.push_back(wr_t'{a: mem_addr, d: mem_wdata});
        check_val("we_one_cycle", {31'd0, prev_we}, 32'd0);
        check_val("wr_latency_window",
                  {31'd0, ((cyc - stop_cyc) >= CPB/2) && ((cyc - stop_cyc) <= CPB/2 + 6)}, 32'd1);
      end
      if (frame_err) begin
        obs_ferr++;
        check_val("fe_one_cycle", {31'd0, prev_fe}, 32'd0);
      end
    end
    prev_we = mem_we;
    prev_fe = frame_err;
  end

  task automatic drive_bit(input logic b);
    rx_data = b;
    repeat (CPB) @(posedge clk);
  endtask

  // Reference model: a completed frame is stored only while loading and not yet full
  task automatic model_byte(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit good;
    good = stop_b;
`ifdef UART_PARITY_EN
    good = good && (par_b == ^d);
`endif
    if (load_en && !exp_done) begin
      if (good) begin
        exp_q.push_back(wr_t'{a: AW'(exp_count), d: d});
        exp_count++;
        if (exp_count == NE) exp_done = 1'b1;
      end else begin
        exp_ferr++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_b,
                           input int gap_bits);
    model_byte(d, stop_b, par_b);
    nbytes++;
    $display("byte %0d: data=0x%02h stop=%0b par=%0b load_en=%0b gap=%0d",
             nbytes, d, stop_b, par_b, load_en, gap_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(par_b);
`endif
    stop_cyc = cyc;
    drive_bit(stop_b);
    repeat (gap_bits) drive_bit(1'b1);
  endtask

  task automatic rearm();
    load_en = 1'b0;
    repeat (3) @(posedge clk);
    exp_count = 0;
    exp_done  = 1'b0;
    load_en   = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic compare_all(input string tag);
    wr_t o, e;
    rx_data = 1'b1;
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    check_val({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_addr"}, {27'd0, o.a}, {27'd0, e.a});
      check_val({tag, "_data"}, {24'd0, o.d}, {24'd0, e.d});
    end
    obs_q.delete();
    exp_q.delete();
    check_val({tag, "_ferr"}, obs_ferr, exp_ferr);
    obs_ferr = 0;
    exp_ferr = 0;
    check_val({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    logic       p;
    int         g;

    rst     = 1'b1;
    load_en = 1'b0;
    rx_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check_val("rst_mem_addr",  {27'd0, mem_addr},  32'd0);
    check_val("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check_val("rst_load_done", {31'd0, load_done}, 32'd0);
    check_val("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Full load of 0x01..0x12, back-to-back
    rearm();
    for (int i = 1; i <= NE; i++) begin
      d = 8'(i);
      send_byte(d, 1'b1, ^d, 0);
    end
    compare_all("full_load");

    // A 19th byte while done is discarded
    d = 8'($urandom);
    send_byte(d, 1'b1, ^d, 0);
    compare_all("extra_in_done");

    // Framing error: byte dropped, next good byte takes the same address
    rearm();
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b1, ^d, 0);
    end
    send_byte(8'hA5, 1'b0, ^8'hA5, 1);
    send_byte(8'h3C, 1'b1, ^8'h3C, 0);
    compare_all("frame_err");

    // Short low glitch on rx
    rx_data = 1'b0;
    repeat (CPB/4) @(posedge clk);
    rx_data = 1'b1;
    repeat (2*CPB) @(posedge clk);
    compare_all("glitch");

    // Abort mid-byte after 5 bytes, rearm, then 0x77 lands at address 0
    rearm();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b1, ^d, 0);
    end
    d = 8'($urandom);
    drive_bit(1'b0);
    drive_bit(d[0]);
    drive_bit(d[1]);
    load_en   = 1'b0;
    exp_count = 0;
    exp_done  = 1'b0;
    for (int i = 2; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(1'b1);
    drive_bit(1'b1);
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    send_byte(8'h77, 1'b1, ^8'h77, 0);
    compare_all("abort");

`ifdef UART_PARITY_EN
    rearm();
    send_byte(8'h03, 1'b1, 1'b1, 0);
    send_byte(8'h03, 1'b1, 1'b0, 0);
    compare_all("parity");
`endif

    // Random frames, gaps and bad stop bits until the load completes
    rearm();
    for (int n = 0; n < 80 && !exp_done; n++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      p = (^d) ^ ($urandom_range(0, 7) == 0);
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_byte(d, s, p, g);
    end
    compare_all("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
